// File: rtl/tx_arbiter_pkg.sv
// Shared defines and types for the tx arbiter slice.
//
// The `define block at the top is the shared defines section for this
// slice: ADDR_SZ is the destination address width and NUM_NODES the
// number of addressable nodes on the serial link. The package turns
// ADDR_SZ into a typed constant and holds the arbiter FSM encoding.
//
// Contents:
//   ADDR_W       destination width (mirrors `ADDR_SZ)
//   arb_state_t  arbiter FSM states

`ifndef TX_ARBITER_DEFINES
`define TX_ARBITER_DEFINES
`define ADDR_SZ 4
`define NUM_NODES 16
`endif

package tx_arbiter_pkg;

  localparam int ADDR_W = `ADDR_SZ;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set bit of 'full', searching
// upward from 'ptr' and wrapping at NUM_REQ.
//
// Ports:
//   full       in   NUM_REQ  candidate vector (slot full bits)
//   ptr        in   IDX_W    index where the search starts
//   winner     out  IDX_W    index of the selected candidate
//   any_valid  out  1        at least one candidate is set

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] full,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int               idx;
  logic [IDX_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the candidate closest to
  // ptr is the last one written and therefore wins.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned; otherwise a latch is inferred.
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (full[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates NUM_REQ request sources onto one shared serial transmitter.
// Each source owns a one-entry holding slot; full slots are granted in
// round-robin order, issued to tx as a one-cycle pulse, and the FSM then
// waits for tx to raise and drop tx_busy before the next grant.
//
// Ports:
//   clk          in   1                 sole clock, rising edge
//   reset        in   1                 synchronous active-high reset
//   src_req      in   NUM_REQ           per-source request pulses
//   src_data     in   NUM_REQ*ADDR_SZ   per-source destination, slice i
//   src_busy     out  NUM_REQ           slot i is full
//   tx_busy      in   1                 busy from the shared tx
//   tx_req       out  1                 registered one-cycle issue pulse
//   tx_data      out  ADDR_SZ           destination, held after issue
//   overflow     out  NUM_REQ           sticky: request hit a full slot
//   timeout_err  out  1                 sticky: tx never acknowledged

module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          src_req,
  input  logic [NUM_REQ*`ADDR_SZ-1:0] src_data,
  output logic [NUM_REQ-1:0]          src_busy,
  input  logic                        tx_busy,
  output logic                        tx_req,
  output logic [`ADDR_SZ-1:0]         tx_data,
  output logic [NUM_REQ-1:0]          overflow,
  output logic                        timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  arb_state_t                       state, state_next;
  logic [NUM_REQ-1:0]               slot_full;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   slot_data;
  logic [IDX_W-1:0]                 rr_ptr;
  logic [IDX_W-1:0]                 win_idx;
  logic [IDX_W-1:0]                 pick_idx;
  logic                             pick_valid;
  logic [CNT_W-1:0]                 wait_cnt;
  logic                             grant;
  logic                             ack_expired;

  assign src_busy = slot_full;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .full      (slot_full),
    .ptr       (rr_ptr),
    .winner    (pick_idx),
    .any_valid (pick_valid)
  );

  // Next-state logic. 'grant' fires on the IDLE->ISSUE transition so the
  // registered tx_req lands exactly in the ISSUE cycle.
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    ack_expired = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid && !tx_busy) begin
          grant      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (wait_cnt == CNT_LAST) begin
          // This cycle is the ACK_TIMEOUT-th one spent without an ack.
          ack_expired = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state       <= IDLE;
      slot_full   <= '0;
      slot_data   <= '0;
      rr_ptr      <= '0;
      win_idx     <= '0;
      wait_cnt    <= '0;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      overflow    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state  <= state_next;
      tx_req <= grant;

      if (grant) begin
        win_idx <= pick_idx;
        rr_ptr  <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        tx_data <= slot_data[pick_idx];
      end

      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT_ACK && !tx_busy && !ack_expired) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (ack_expired) timeout_err <= 1'b1;

      // The winner slot stays full through ISSUE, so a request for it in
      // the grant cycle counts as an overflow and is dropped.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (state == ISSUE && win_idx == IDX_W'(i)) slot_full[i] <= 1'b0;
        if (src_req[i]) begin
          if (slot_full[i]) begin
            overflow[i] <= 1'b1;
          end else begin
            slot_full[i] <= 1'b1;
            slot_data[i] <= src_data[i*`ADDR_SZ +: `ADDR_SZ];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter (NUM_REQ=4, ACK_TIMEOUT=15, ADDR_SZ=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at
// that same point, so "cycle t" is the interval following edge t.

module tb_tx_arbiter;
  import tx_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = ADDR_W;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    src_req;
  logic [N*AW-1:0] src_data;
  logic [N-1:0]    src_busy;
  logic            tx_busy;
  logic            tx_req;
  logic [AW-1:0]   tx_data;
  logic [N-1:0]    overflow;
  logic            timeout_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  tx_arbiter #(
    .NUM_REQ     (N),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src_req     (src_req),
    .src_data    (src_data),
    .src_busy    (src_busy),
    .tx_busy     (tx_busy),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    src_req  = '0;
    src_data = '0;
    tx_busy  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_data(input logic [AW-1:0] d0, input logic [AW-1:0] d1,
                          input logic [AW-1:0] d2, input logic [AW-1:0] d3);
    src_data = {d3, d2, d1, d0};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_req"},   32'(tx_req),      0);
    check({tag, "_tx_data"},  32'(tx_data),     0);
    check({tag, "_src_busy"}, 32'(src_busy),    0);
    check({tag, "_overflow"}, 32'(overflow),    0);
    check({tag, "_timeout"},  32'(timeout_err), 0);
  endtask

  // Wait (bounded) for an issue pulse, capture its data, then act as the
  // tx: raise tx_busy in the WAIT_ACK cycle for busy_len cycles.
  task automatic serve(input string tag, input int busy_len, output logic [AW-1:0] data);
    bit found;
    found = 1'b0;
    data  = '0;
    for (int i = 0; i < 40; i++) begin
      if (tx_req) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_issue_seen"}, 32'(found), 1);
    if (found) begin
      data = tx_data;
      tick();
      check({tag, "_no_b2b"}, 32'(tx_req), 0);
      tx_busy = 1'b1;
      repeat (busy_len) tick();
      tx_busy = 1'b0;
    end
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      tick();
      if (tx_req) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] d;
    int            n;

    // Reset state
    do_reset();
    check_all_zero("rst");

    // Single request, latency and busy window
    src_req = 4'b0100;
    set_data(4'h0, 4'h0, 4'h5, 4'h0);
    tick();                               // t+1
    src_req = '0;
    check("lat_busy_t1", 32'(src_busy), 32'h4);
    check("lat_req_t1",  32'(tx_req),   0);
    tick();                               // t+2
    check("lat_req_t2",  32'(tx_req),   1);
    check("lat_data_t2", 32'(tx_data),  5);
    check("lat_busy_t2", 32'(src_busy), 32'h4);
    tick();                               // t+3
    check("lat_busy_t3", 32'(src_busy), 0);
    check("lat_req_t3",  32'(tx_req),   0);
    check("lat_hold_t3", 32'(tx_data),  5);
    tx_busy = 1'b1;
    tick();
    tick();
    tx_busy = 1'b0;
    tick();

    // All four at once, round-robin from pointer 0
    do_reset();
    src_req = 4'b1111;
    set_data(4'h1, 4'h2, 4'h3, 4'h4);
    tick();
    src_req = '0;
    check("rr4_busy", 32'(src_busy), 32'hF);
    tick();
    check("rr4_first_t2", 32'(tx_req), 1);
    for (int k = 0; k < 4; k++) begin
      serve($sformatf("rr4_%0d", k), 3, d);
      check($sformatf("rr4_order%0d", k), 32'(d), k + 1);
    end
    count_pulses(10, n);
    check("rr4_no_extra", 32'(n), 0);
    check("rr4_empty", 32'(src_busy), 0);

    // Overflow on a full slot
    do_reset();
    src_req = 4'b0010;
    set_data(4'h0, 4'h7, 4'h0, 4'h0);
    tick();
    set_data(4'h0, 4'h9, 4'h0, 4'h0);
    tick();                               // t+2
    src_req = '0;
    check("ovf_flag", 32'(overflow), 32'h2);
    check("ovf_req",  32'(tx_req),   1);
    check("ovf_data", 32'(tx_data),  7);
    serve("ovf", 2, d);
    check("ovf_issued", 32'(d), 7);
    count_pulses(30, n);
    check("ovf_second_dropped", 32'(n), 0);
    check("ovf_sticky", 32'(overflow), 32'h2);
    check("ovf_empty",  32'(src_busy), 0);

    // Ack timeout then next pending slot
    do_reset();
    src_req = 4'b0011;
    set_data(4'hA, 4'hB, 4'h0, 4'h0);
    tick();
    src_req = '0;
    tick();                               // t+2
    check("to_req1",  32'(tx_req),  1);
    check("to_data1", 32'(tx_data), 32'hA);
    repeat (15) tick();                   // t+17: last WAIT_ACK cycle
    check("to_not_yet", 32'(timeout_err), 0);
    tick();                               // t+18: back in IDLE
    check("to_set",     32'(timeout_err), 1);
    check("to_req_t18", 32'(tx_req),      0);
    tick();                               // t+19
    check("to_req2",    32'(tx_req),   1);
    check("to_data2",   32'(tx_data),  32'hB);
    check("to_busy2",   32'(src_busy), 32'h2);
    count_pulses(20, n);
    check("to_no_more", 32'(n), 0);
    check("to_sticky",  32'(timeout_err), 1);

    // Reset in WAIT_DONE with slots 0 and 3 full
    do_reset();
    src_req = 4'b1001;
    set_data(4'h3, 4'h0, 4'h0, 4'hC);
    tick();
    src_req = '0;
    tick();                               // t+2
    check("rstmid_req",  32'(tx_req),  1);
    check("rstmid_data", 32'(tx_data), 3);
    tick();                               // t+3 WAIT_ACK
    tx_busy = 1'b1;
    src_req = 4'b0001;
    set_data(4'h6, 4'h0, 4'h0, 4'hC);
    tick();                               // t+4 WAIT_DONE
    check("rstmid_busy", 32'(src_busy), 32'h9);
    reset   = 1'b1;
    src_req = 4'b0001;
    tick();
    check_all_zero("rstmid");
    reset   = 1'b0;
    src_req = '0;
    tx_busy = 1'b0;
    count_pulses(20, n);
    check("rstmid_no_issue", 32'(n), 0);
    check("rstmid_empty", 32'(src_busy), 0);

    // Pointer wrap: grant 3, then 0 beats 3
    do_reset();
    src_req = 4'b1000;
    set_data(4'h0, 4'h0, 4'h0, 4'h8);
    tick();
    src_req = '0;
    serve("wrap_a", 1, d);
    check("wrap_first", 32'(d), 8);
    src_req = 4'b1001;
    set_data(4'h1, 4'h0, 4'h0, 4'h2);
    tick();
    src_req = '0;
    serve("wrap_b", 1, d);
    check("wrap_slot0", 32'(d), 1);
    serve("wrap_c", 1, d);
    check("wrap_slot3", 32'(d), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of source requesters sharing one tx (2..8).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, max cycles waiting for tx_busy rise after issue.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port src_req  input  NUM_REQ  per-source one-cycle request pulses.
REQ-007 SHALL have port src_data  input  NUM_REQ*`ADDR_SZ  flattened per-source destination, slice i at [i*`ADDR_SZ +: `ADDR_SZ].
REQ-008 SHALL have port src_busy  output  NUM_REQ  per-source busy, high while that source's holding slot is full.
REQ-009 SHALL have port tx_busy  input  1  busy from the shared serial tx.
REQ-010 SHALL have port tx_req  output  1  one-cycle issue pulse to tx.
REQ-011 SHALL have port tx_data  output  `ADDR_SZ  destination presented to tx, valid when tx_req=1.
REQ-012 SHALL have port overflow  output  NUM_REQ  sticky per-source flag, request arrived while slot full.
REQ-013 SHALL have port timeout_err  output  1  sticky flag, tx never acknowledged an issue.

Function
REQ-014 SHALL hold one slot (full bit + `ADDR_SZ data) per source; src_req[i] with slot i empty captures src_data slice i, full visible next cycle.
REQ-015 SHALL drop src_req[i] arriving while slot i full (including its grant cycle) and set overflow[i].
REQ-016 SHALL drive src_busy[i] directly from slot i full bit.
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-018 IDLE: if any slot full and tx_busy=0, select winner round-robin, register it, go ISSUE; else stay.
REQ-019 Round-robin: search starts at pointer p (reset 0); after granting i, p = (i+1) mod NUM_REQ.
REQ-020 ISSUE: tx_req=1 for exactly that cycle, tx_data = winner slot data, winner slot cleared, go WAIT_ACK.
REQ-021 WAIT_ACK: tx_busy=1 -> WAIT_DONE; else increment wait counter; counter reaching ACK_TIMEOUT -> set timeout_err, go IDLE.
REQ-022 WAIT_DONE: stay while tx_busy=1; tx_busy=0 -> IDLE.
REQ-023 Latency: src_req at cycle t into empty slot, FSM in IDLE, tx idle -> tx_req high at t+2.
REQ-024 tx_data SHALL hold last issued value outside ISSUE; tx_req SHALL be registered, never combinational.
REQ-025 At most one issue per FSM round trip; no back-to-back tx_req pulses.
REQ-026 Wait counter width SHALL fit ACK_TIMEOUT; cleared on entry to WAIT_ACK.

Reset
REQ-027 Reset SHALL force: state IDLE, all slots empty, p=0, wait counter 0, tx_req=0, tx_data=0, src_busy=0, overflow=0, timeout_err=0.
REQ-028 Reset mid-transfer SHALL discard all pending slots; src_req during reset cycle SHALL be ignored.
REQ-029 overflow and timeout_err SHALL clear only on reset.

Structure
REQ-030 `ADDR_SZ and `NUM_NODES SHALL come from the shared defines include; FSM encodings local parameters.
REQ-031 Round-robin select SHALL be sub-module rr_pick (inputs full vector, pointer; outputs winner index, any_valid).
REQ-032 Total RTL 120-400 lines; no memories, single always block for state.

Verification (`ADDR_SZ=4, NUM_REQ=4)
REQ-033 src_req[2] pulse, data 4'h5, tx idle -> tx_req at t+2, tx_data=5, src_busy[2] high t+1..t+2, low t+3.
REQ-034 src_req=4'b1111 same cycle, data 1,2,3,4, tx busy 3 cycles per issue -> issue order 1,2,3,4, four distinct tx_req pulses.
REQ-035 Slot 1 full, second src_req[1] -> overflow[1]=1, first data still issued, second never issued.
REQ-036 Issue with tx_busy stuck 0 -> timeout_err=1 after 15 WAIT_ACK cycles, FSM back to IDLE, next pending slot issued.
REQ-037 Reset asserted in WAIT_DONE with slots 0,3 full -> next cycle all outputs 0, no tx_req after release without new requests.
REQ-038 Grant 3 then slots 0,3 refilled -> slot 0 granted before slot 3 (pointer wrap).
